// File: rtl/jtframe_ddram_bram.sv
// ---------------------------------------------------------------------------
// jtframe_ddram_bram
//
// This module answers the 64-bit DDRAM-style burst bus from on-chip block RAM.
// The line-frame buffer initiator drives that bus. With this module the DECA
// builds can run the line-frame buffer without an external DDR3 controller.
// The storage is a single-port RAM of 2^AW 64-bit words. The module runs in
// the clk_rom domain.
//
// Parameters
//   AW       word-address width of the internal RAM
//   LATENCY  extra wait cycles between read acceptance and the first beat
//   CLEAR    when 1, the RAM is zero-filled after reset (busy held high)
//
// Ports
//   rst               asynchronous active-high reset
//   clk               clock, all logic on its rising edge
//   ddram_busy        responder cannot accept a new command
//   ddram_addr        64-bit word address, only [AW-1:0] used
//   ddram_burstcnt    beats per burst, 0 behaves as 1
//   ddram_rd          read command (sampled while busy is low)
//   ddram_we          write beat valid
//   ddram_din         write data
//   ddram_be          byte enables, bit i covers din[8i+7:8i]
//   ddram_dout        read data, holds the last beat
//   ddram_dout_ready  ddram_dout valid this cycle
//   err               sticky protocol-violation flag
// ---------------------------------------------------------------------------
module jtframe_ddram_bram #(
  parameter int AW      = 14,
  parameter int LATENCY = 0,
  parameter int CLEAR   = 1
) (
  input  logic        rst,
  input  logic        clk,
  output logic        ddram_busy,
  input  logic [28:0] ddram_addr,
  input  logic [7:0]  ddram_burstcnt,
  input  logic        ddram_rd,
  input  logic        ddram_we,
  input  logic [63:0] ddram_din,
  input  logic [7:0]  ddram_be,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_ready,
  output logic        err
);

  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_WR,
    ST_RWAIT,
    ST_RD
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    beat_q, beat_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          rvalid_q, rvalid_d;
  logic [63:0]   dout_q, dout_d;
  logic          dout_ready_q, dout_ready_d;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_re;
  logic [7:0]    ram_be;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;
  logic [63:0]   mem [2**AW];

  logic [7:0]    burst_cnt;
  logic [AW-1:0] beat_addr;
  logic          addr_unused;

  // The upper address bits are ignored by design.
  assign addr_unused = ^ddram_addr[28:AW];

  // A burst count of zero behaves as one beat. Beat addresses wrap at the
  // top of the RAM through natural AW-bit truncation.
  assign burst_cnt = (ddram_burstcnt == 8'd0) ? 8'd1 : ddram_burstcnt;
  assign beat_addr = base_q + AW'(beat_q);

  // Next-state logic and the single RAM port mux. Only one of the clear
  // pass, the write beats and the read issues owns the RAM in any cycle.
  // Every read issue sets rvalid. rvalid then moves the RAM output into the
  // dout register one cycle later.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    lat_d        = lat_q;
    clr_addr_d   = clr_addr_q;
    busy_d       = busy_q;
    err_d        = err_q;
    ram_addr     = beat_addr;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_be       = ddram_be;
    ram_wdata    = ddram_din;

    case (state_q)
      ST_CLR: begin
        ram_we     = 1'b1;
        ram_addr   = clr_addr_q;
        ram_wdata  = '0;
        ram_be     = '1;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == '1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_IDLE: begin
        if (ddram_we) begin
          // A write wins over a simultaneous read. The read is dropped and
          // flagged.
          ram_we   = 1'b1;
          ram_addr = ddram_addr[AW-1:0];
          base_d   = ddram_addr[AW-1:0];
          cnt_d    = burst_cnt;
          beat_d   = 8'd1;
          if (ddram_rd) err_d = 1'b1;
          if (burst_cnt != 8'd1) state_d = ST_WR;
        end else if (ddram_rd) begin
          base_d = ddram_addr[AW-1:0];
          cnt_d  = burst_cnt;
          busy_d = 1'b1;
          if (LATENCY == 0) begin
            ram_re   = 1'b1;
            ram_addr = ddram_addr[AW-1:0];
            beat_d   = 8'd1;
            state_d  = ST_RD;
          end else begin
            lat_d   = LW'(LATENCY - 1);
            beat_d  = 8'd0;
            state_d = ST_RWAIT;
          end
        end
      end

      ST_WR: begin
        if (ddram_rd) err_d = 1'b1;
        if (ddram_we) begin
          ram_we = 1'b1;
          beat_d = beat_q + 8'd1;
          if ((beat_q + 8'd1) == cnt_q) state_d = ST_IDLE;
        end
      end

      ST_RWAIT: begin
        // The last wait cycle already issues beat 0. The first beat then
        // appears LATENCY cycles after it would with no wait.
        if (lat_q == '0) begin
          ram_re  = 1'b1;
          beat_d  = 8'd1;
          state_d = ST_RD;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end

      ST_RD: begin
        // The state stays here one cycle after the last issue. busy then
        // drops in the same cycle as the last dout_ready.
        if (beat_q != cnt_q) begin
          ram_re = 1'b1;
          beat_d = beat_q + 8'd1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The read data pipeline output stage. dout keeps its value between
  // bursts.
  always_comb begin
    rvalid_d     = ram_re;
    dout_ready_d = rvalid_q;
    dout_d       = rvalid_q ? ram_rdata : dout_q;
  end

  // Control and output registers. An asynchronous reset kills any burst in
  // flight. It also restarts the clear pass when CLEAR is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= (CLEAR != 0) ? ST_CLR : ST_IDLE;
      base_q       <= '0;
      cnt_q        <= 8'd0;
      beat_q       <= 8'd0;
      lat_q        <= '0;
      clr_addr_q   <= '0;
      busy_q       <= (CLEAR != 0);
      err_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      dout_q       <= 64'd0;
      dout_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      lat_q        <= lat_d;
      clr_addr_q   <= clr_addr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      rvalid_q     <= rvalid_d;
      dout_q       <= dout_d;
      dout_ready_q <= dout_ready_d;
    end
  end

  // The block RAM has a byte-write port and a registered read. It has no
  // reset, so its contents survive rst unless the clear pass rewrites them.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 8; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  assign ddram_busy       = busy_q;
  assign ddram_dout       = dout_q;
  assign ddram_dout_ready = dout_ready_q;
  assign err              = err_q;

endmodule

// File: tb/tb_jtframe_ddram_bram.sv
// ---------------------------------------------------------------------------
// tb_jtframe_ddram_bram
//
// This bench drives two responders (AW=4, CLEAR=1) from the same bus inputs.
// One has LATENCY=0 and the other has LATENCY=3. Every read checks both
// instances against their own expected beat timing.
// ---------------------------------------------------------------------------
module tb_jtframe_ddram_bram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [28:0] ddram_addr = '0;
  logic [7:0]  ddram_burstcnt = '0;
  logic        ddram_rd = 1'b0;
  logic        ddram_we = 1'b0;
  logic [63:0] ddram_din = '0;
  logic [7:0]  ddram_be = '0;

  logic        busy0, rdy0, err0;
  logic [63:0] dout0;
  logic        busy3, rdy3, err3;
  logic [63:0] dout3;

  jtframe_ddram_bram #(.AW(4), .LATENCY(0), .CLEAR(1)) dut0 (
    .rst(rst), .clk(clk), .ddram_busy(busy0), .ddram_addr(ddram_addr),
    .ddram_burstcnt(ddram_burstcnt), .ddram_rd(ddram_rd), .ddram_we(ddram_we),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(dout0),
    .ddram_dout_ready(rdy0), .err(err0)
  );

  jtframe_ddram_bram #(.AW(4), .LATENCY(3), .CLEAR(1)) dut3 (
    .rst(rst), .clk(clk), .ddram_busy(busy3), .ddram_addr(ddram_addr),
    .ddram_burstcnt(ddram_burstcnt), .ddram_rd(ddram_rd), .ddram_we(ddram_we),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(dout3),
    .ddram_dout_ready(rdy3), .err(err3)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_data [16];

  typedef struct {
    logic        wr;
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic rd, input logic we, input logic [28:0] a,
                               input logic [7:0] bc, input logic [63:0] d, input logic [7:0] be);
    @(negedge clk);
    ddram_rd       = rd;
    ddram_we       = we;
    ddram_addr     = a;
    ddram_burstcnt = bc;
    ddram_din      = d;
    ddram_be       = be;
  endtask

  task automatic applyIdle();
    @(negedge clk);
    ddram_rd = 1'b0;
    ddram_we = 1'b0;
  endtask

  // Cycle k after the command: beats occupy k = 2+lat .. 1+lat+cnt. busy is
  // high for k = 1 .. lat+cnt. dout keeps the last beat afterwards.
  task automatic checkBeat(input string tag, input int lat, input int k, input int cnt,
                           input logic rdy, input logic busy, input logic [63:0] dout);
    logic exp_rdy, exp_busy;
    exp_rdy  = (k >= 2 + lat) && (k < 2 + lat + cnt);
    exp_busy = (k <= lat + cnt);
    checkOutput($sformatf("%s_rdy_k%0d", tag, k), {63'd0, rdy}, {63'd0, exp_rdy});
    checkOutput($sformatf("%s_busy_k%0d", tag, k), {63'd0, busy}, {63'd0, exp_busy});
    if (exp_rdy)
      checkOutput($sformatf("%s_dout_k%0d", tag, k), dout, exp_data[k-2-lat]);
    if (k == 2 + lat + cnt)
      checkOutput($sformatf("%s_hold_k%0d", tag, k), dout, exp_data[cnt-1]);
  endtask

  task automatic checkRead(input logic [28:0] a, input logic [7:0] bc);
    int cnt;
    cnt = (bc == 8'd0) ? 1 : int'(bc);
    applyStimulus(1'b1, 1'b0, a, bc, 64'd0, 8'd0);
    for (int k = 1; k <= cnt + 7; k++) begin
      @(negedge clk);
      if (k == 1) ddram_rd = 1'b0;
      checkBeat("l0", 0, k, cnt, rdy0, busy0, dout0);
      checkBeat("l3", 3, k, cnt, rdy3, busy3, dout3);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c3, r0, r3;

    vecs[0] = '{1'b1, 29'd9,         64'h1122334455667788, 8'hFF, 64'd0};
    vecs[1] = '{1'b1, 29'd9,         64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'd0};
    vecs[2] = '{1'b0, 29'd9,         64'd0,                8'h00, 64'h11223344FFFFFFFF};
    vecs[3] = '{1'b1, 29'h1FFFFFF3,  64'hDEADBEEFCAFEF00D, 8'hFF, 64'd0};
    vecs[4] = '{1'b0, 29'd3,         64'd0,                8'h00, 64'hDEADBEEFCAFEF00D};
    vecs[5] = '{1'b1, 29'd3,         64'h0000000000000000, 8'h00, 64'd0};
    vecs[6] = '{1'b0, 29'h10000003,  64'd0,                8'h00, 64'hDEADBEEFCAFEF00D};
    vecs[7] = '{1'b1, 29'd3,         64'h5500000000000000, 8'h80, 64'd0};
    vecs[8] = '{1'b0, 29'd3,         64'd0,                8'h00, 64'h55ADBEEFCAFEF00D};

    // The reset state is checked while rst is held.
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy0", {63'd0, busy0}, 64'd1);
    checkOutput("rst_busy3", {63'd0, busy3}, 64'd1);
    checkOutput("rst_dout0", dout0, 64'd0);
    checkOutput("rst_rdy0", {63'd0, rdy0}, 64'd0);
    checkOutput("rst_err0", {63'd0, err0}, 64'd0);
    checkOutput("rst_err3", {63'd0, err3}, 64'd0);

    // The clear pass keeps busy high for 16 cycles after release.
    rst = 1'b0;
    c0 = 0; c3 = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy0) c0++;
      if (busy3) c3++;
      @(negedge clk);
    end
    checkOutput("clr_busy_cycles0", 64'(c0), 64'd16);
    checkOutput("clr_busy_cycles3", 64'(c3), 64'd16);
    for (int i = 0; i < 16; i++) exp_data[i] = 64'd0;
    checkRead(29'd0, 8'd16);

    // Write burst with two idle cycles between beats. addr and burstcnt
    // carry junk after beat 0.
    applyStimulus(1'b0, 1'b1, 29'd5, 8'd3, 64'hA1, 8'hFF);
    applyIdle();
    checkOutput("wr_busy0", {63'd0, busy0}, 64'd0);
    applyIdle();
    applyStimulus(1'b0, 1'b1, 29'h1234, 8'd7, 64'hA2, 8'hFF);
    applyIdle();
    checkOutput("wr_busy3", {63'd0, busy3}, 64'd0);
    applyIdle();
    applyStimulus(1'b0, 1'b1, 29'h0, 8'd0, 64'hA3, 8'hFF);
    applyIdle();
    exp_data[0] = 64'hA1; exp_data[1] = 64'hA2; exp_data[2] = 64'hA3;
    checkRead(29'd5, 8'd3);

    // Single-beat vectors cover byte enables, be=0 and ignored upper bits.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) begin
        applyStimulus(1'b0, 1'b1, vecs[i].addr, 8'd1, vecs[i].din, vecs[i].be);
        applyIdle();
      end else begin
        exp_data[0] = vecs[i].exp;
        checkRead(vecs[i].addr, 8'd1);
      end
    end

    // The write burst wraps from address 15 to address 0.
    applyStimulus(1'b0, 1'b1, 29'd14, 8'd4, 64'd0, 8'hFF);
    applyStimulus(1'b0, 1'b1, 29'd14, 8'd4, 64'd1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 29'd14, 8'd4, 64'd2, 8'hFF);
    applyStimulus(1'b0, 1'b1, 29'd14, 8'd4, 64'd3, 8'hFF);
    applyIdle();
    exp_data[0] = 64'd2; exp_data[1] = 64'd3;
    checkRead(29'd0, 8'd2);
    exp_data[0] = 64'd0;
    checkRead(29'd14, 8'd0);

    // With rd and we together, the write lands, the read is dropped and err
    // sticks.
    checkOutput("pre_err0", {63'd0, err0}, 64'd0);
    checkOutput("pre_err3", {63'd0, err3}, 64'd0);
    applyStimulus(1'b1, 1'b1, 29'd7, 8'd1, 64'h7777777777777777, 8'hFF);
    applyIdle();
    r0 = 0; r3 = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdy0) r0++;
      if (rdy3) r3++;
      @(negedge clk);
    end
    checkOutput("rdwe_no_rdy0", 64'(r0), 64'd0);
    checkOutput("rdwe_no_rdy3", 64'(r3), 64'd0);
    checkOutput("rdwe_err0", {63'd0, err0}, 64'd1);
    checkOutput("rdwe_err3", {63'd0, err3}, 64'd1);
    exp_data[0] = 64'h7777777777777777;
    checkRead(29'd7, 8'd1);
    checkOutput("err_sticky0", {63'd0, err0}, 64'd1);
    checkOutput("err_sticky3", {63'd0, err3}, 64'd1);

    // The LATENCY=3 instance is reset during beat 1 of a 4-beat read.
    applyStimulus(1'b1, 1'b0, 29'd5, 8'd4, 64'd0, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) ddram_rd = 1'b0;
      if (k == 4) checkOutput("lat3_early_rdy", {63'd0, rdy3}, 64'd0);
      if (k == 5) begin
        checkOutput("lat3_beat0_rdy", {63'd0, rdy3}, 64'd1);
        checkOutput("lat3_beat0_dout", dout3, 64'hA1);
      end
      if (k == 6) begin
        checkOutput("lat3_beat1_rdy", {63'd0, rdy3}, 64'd1);
        checkOutput("lat3_beat1_dout", dout3, 64'hA2);
      end
    end
    rst = 1'b1;
    #1;
    checkOutput("abort_rdy3", {63'd0, rdy3}, 64'd0);
    checkOutput("abort_busy3", {63'd0, busy3}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r3 = 0; c3 = 0;
    for (int i = 0; i < 24; i++) begin
      if (rdy3) r3++;
      if (busy3) c3++;
      @(negedge clk);
    end
    checkOutput("abort_no_beats", 64'(r3), 64'd0);
    checkOutput("abort_clr_cycles", 64'(c3), 64'd16);
    checkOutput("abort_err3", {63'd0, err3}, 64'd0);
    checkOutput("abort_err0", {63'd0, err0}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
